// File: rtl/interconnect_mfft_to_two_sfft_pkg.sv
// Shared definitions for the mFFT <-> two-sFFT interconnects: frame sizing and FSM encoding.
// Also imported by interconnect_two_sfft_to_mfft.
package interconnect_mfft_to_two_sfft_pkg;

  localparam int unsigned SizeBufferDefault = 3;
  localparam int unsigned NfftDefault       = 1 << SizeBufferDefault;
  localparam int unsigned NfftHalfDefault   = NfftDefault / 2;

  typedef enum logic {
    StFill,
    StDrain
  } fft_state_e;

  function automatic int unsigned nfft_f(input int unsigned size_buffer);
    return 1 << size_buffer;
  endfunction

  function automatic int unsigned nfft_half_f(input int unsigned size_buffer);
    return (1 << size_buffer) / 2;
  endfunction

endpackage

// File: rtl/interconnect_mfft_to_two_sfft_bank.sv
// Simple dual-port bank for one half of the split frame: one write port, registered read.
// Contents are intentionally not reset.
module sfft_split_bank #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    // rd_data holds when not enabled; the output stage relies on that while stalled.
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/interconnect_mfft_to_two_sfft.sv
// Splits a natural-order frame of NFFT complex samples into even/odd streams for two
// half-size FFTs. Frame is buffered in two banks, then drained pairwise with backpressure.
module interconnect_mfft_to_two_sfft
  import interconnect_mfft_to_two_sfft_pkg::*;
#(
  parameter int unsigned SIZE_BUFFER = SizeBufferDefault,
  parameter int unsigned SIZE_DATA   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SIZE_DATA-1:0] in_i,
  input  logic [SIZE_DATA-1:0] in_q,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [SIZE_DATA-1:0] data_chet_i,
  output logic [SIZE_DATA-1:0] data_chet_q,
  output logic [SIZE_DATA-1:0] data_Nchet_i,
  output logic [SIZE_DATA-1:0] data_Nchet_q,
  output logic                 valid_chet,
  output logic                 valid_Nchet,
  input  logic                 resiveChet,
  input  logic                 resiveNChet,
  output logic                 out_last,
  output logic                 frameDone
);

  localparam int unsigned Nfft     = nfft_f(SIZE_BUFFER);
  localparam int unsigned NfftHalf = nfft_half_f(SIZE_BUFFER);
  localparam int unsigned AddrW    = SIZE_BUFFER - 1;
  localparam int unsigned DataW    = 2 * SIZE_DATA;

  localparam logic [SIZE_BUFFER-1:0] InLastIdx = SIZE_BUFFER'(Nfft - 1);
  localparam logic [SIZE_BUFFER-1:0] RdEnd     = SIZE_BUFFER'(NfftHalf);
  localparam logic [SIZE_BUFFER-1:0] RdLastIdx = SIZE_BUFFER'(NfftHalf - 1);
  localparam logic [AddrW-1:0]       OutLastIdx = AddrW'(NfftHalf - 1);

  fft_state_e state_q, state_d;

  logic [SIZE_BUFFER-1:0] in_cnt_q, in_cnt_d;
  logic [SIZE_BUFFER-1:0] rd_cnt_q, rd_cnt_d;
  logic [AddrW-1:0]       out_cnt_q, out_cnt_d;
  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_last_q, s1_last_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic                   frame_done_q, frame_done_d;
  logic [DataW-1:0]       out_even_q, out_even_d;
  logic [DataW-1:0]       out_odd_q, out_odd_d;

  logic             in_xfer;
  logic             even_we, odd_we;
  logic [AddrW-1:0] wr_addr;
  logic [DataW-1:0] wr_data;
  logic             rd_en;
  logic [AddrW-1:0] rd_addr;
  logic [DataW-1:0] even_rd, odd_rd;
  logic             accept;
  logic             load_out;
  logic             last_accept;

  // Input side: sample parity selects the bank, upper index bits address it.
  always_comb begin
    in_ready = (state_q == StFill);
    in_xfer  = in_ready & in_valid;
    wr_addr  = in_cnt_q[SIZE_BUFFER-1:1];
    wr_data  = {in_i, in_q};
    even_we  = in_xfer & ~in_cnt_q[0];
    odd_we   = in_xfer & in_cnt_q[0];
  end

  // Two-stage output pipeline: bank read register (s1) feeding the output register.
  // Reading one pair ahead keeps a pair per cycle flowing when both sinks are ready.
  always_comb begin
    accept      = out_valid_q & resiveChet & resiveNChet;
    load_out    = s1_valid_q & (~out_valid_q | accept);
    rd_en       = (state_q == StDrain) & (rd_cnt_q < RdEnd) & (~s1_valid_q | load_out);
    rd_addr     = rd_cnt_q[AddrW-1:0];
    last_accept = accept & (out_cnt_q == OutLastIdx);
  end

  sfft_split_bank #(
    .ADDR_W (AddrW),
    .DATA_W (DataW)
  ) u_even_bank (
    .clk     (clk),
    .wr_en   (even_we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (even_rd)
  );

  sfft_split_bank #(
    .ADDR_W (AddrW),
    .DATA_W (DataW)
  ) u_odd_bank (
    .clk     (clk),
    .wr_en   (odd_we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (odd_rd)
  );

  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    out_cnt_d    = out_cnt_q;
    s1_valid_d   = s1_valid_q;
    s1_last_d    = s1_last_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_even_d   = out_even_q;
    out_odd_d    = out_odd_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      StFill: begin
        if (in_xfer) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == InLastIdx) begin
            state_d  = StDrain;
            in_cnt_d = '0;
            rd_cnt_d = '0;
          end
        end
      end
      StDrain: begin
        if (rd_en) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (last_accept) begin
          state_d      = StFill;
          frame_done_d = 1'b1;
          rd_cnt_d     = '0;
        end
      end
      default: state_d = StFill;
    endcase

    if (rd_en) begin
      s1_valid_d = 1'b1;
      s1_last_d  = (rd_cnt_q == RdLastIdx);
    end else if (load_out) begin
      s1_valid_d = 1'b0;
    end

    if (load_out) begin
      out_valid_d = 1'b1;
      out_last_d  = s1_last_q;
      out_even_d  = even_rd;
      out_odd_d   = odd_rd;
    end else if (accept) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (accept) begin
      out_cnt_d = out_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StFill;
      in_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      out_cnt_q    <= '0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      out_even_q   <= '0;
      out_odd_q    <= '0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      out_cnt_q    <= out_cnt_d;
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      out_even_q   <= out_even_d;
      out_odd_q    <= out_odd_d;
    end
  end

  always_comb begin
    data_chet_i  = out_even_q[DataW-1:SIZE_DATA];
    data_chet_q  = out_even_q[SIZE_DATA-1:0];
    data_Nchet_i = out_odd_q[DataW-1:SIZE_DATA];
    data_Nchet_q = out_odd_q[SIZE_DATA-1:0];
    valid_chet   = out_valid_q;
    valid_Nchet  = out_valid_q;
    out_last     = out_last_q;
    frameDone    = frame_done_q;
  end

endmodule

// File: doc/interconnect_mfft_to_two_sfft.md
INTERCONNECT_MFFT_TO_TWO_SFFT -- requirements
Module: interconnect_mFFT_to_two_sFFT

Interface
REQ-001 Parameter SIZE_BUFFER, default 3: log2(NFFT); legal range 2..12; NFFT = 1 << SIZE_BUFFER.
REQ-002 Parameter SIZE_DATA, default 16: width of each I/Q sample, two's complement.
REQ-003 clk  in  1  clock; all logic is on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_i, in_q  in  SIZE_DATA each  input sample in natural time order.
REQ-006 in_valid  in  1  input sample present.
REQ-007 in_ready  out  1  block accepts a sample this cycle.
REQ-008 data_chet_i, data_chet_q  out  SIZE_DATA each  even-indexed samples, to the even sub-FFT.
REQ-009 data_Nchet_i, data_Nchet_q  out  SIZE_DATA each  odd-indexed samples, to the odd sub-FFT.
REQ-010 valid_chet, valid_Nchet  out  1 each  output pair present; both are always equal.
REQ-011 resiveChet, resiveNChet  in  1 each  the even/odd sub-FFT accepts a sample.
REQ-012 out_last  out  1  marks output pair index NFFT/2-1.
REQ-013 frameDone  out  1  one-cycle pulse after the final pair is accepted.

Function
REQ-014 The FSM has two states: FILL (accept input) and DRAIN (emit pairs).
REQ-015 In FILL, in_ready=1; a sample transfers when in_valid&in_ready.
REQ-016 Input index in_cnt[SIZE_BUFFER-1:0] increments per transfer.
REQ-017 Sample n is written to even bank address n>>1 when n[0]=0, else to odd bank address n>>1.
REQ-018 Gaps in in_valid stall in_cnt without loss.
REQ-019 The transfer with in_cnt=NFFT-1 moves FILL->DRAIN at the next edge, resets in_cnt to 0, and drops in_ready.
REQ-020 In DRAIN, in_ready=0; in_valid is ignored.
REQ-021 Output index out_cnt[SIZE_BUFFER-2:0] starts at 0.
REQ-022 Pair k is even[k], odd[k]; outputs are registered.
REQ-023 Latency: if the last input transfers at edge T, valid_* is first high after edge T+2 with pair 0.
REQ-024 A pair advances only when valid & resiveChet & resiveNChet.
REQ-025 If either ready input is low, data, valid and out_last hold stable; no pair is skipped or duplicated.
REQ-026 With both ready inputs held high, one pair is emitted per cycle with no bubbles.
REQ-027 When pair NFFT/2-1 transfers: valid and out_last drop next cycle, frameDone pulses that cycle, out_cnt wraps to 0, FSM returns to FILL, and in_ready=1 that same cycle.
REQ-028 Data passes through unmodified; no arithmetic, scaling or sign change.

Reset
REQ-029 Reset, which has priority over all other events, gives: FSM=FILL, in_cnt=0, out_cnt=0, in_ready=1, valid_*=0, out_last=0, frameDone=0, data outputs=0.
REQ-030 Reset mid-FILL or mid-DRAIN discards the partial frame; the next accepted sample is index 0.
REQ-031 Bank memories are not reset; stale contents are never emitted.

Structure
REQ-032 A shared package holds the NFFT and NFFT/2 localparams derived from SIZE_BUFFER and the FSM state encoding.
REQ-033 The package is shared with interconnect_two_sFFT_to_mFFT.
REQ-034 One sub-module, sfft_split_bank, is instantiated twice: a simple dual-port RAM, NFFT/2 x 2*SIZE_DATA, one write port, registered one-cycle read.
REQ-035 The output stage prefetches from the bank so REQ-026 holds.

Verification
REQ-036 Scenario: NFFT=8, input I=0..7 (Q=I+100), both ready inputs high -> chet I=0,2,4,6 and Nchet I=1,3,5,7; out_last on the 4th pair; frameDone once; latency per REQ-023.
REQ-037 Scenario: in_valid toggling 1,0 per cycle -> identical output order; in_cnt stalls during gaps.
REQ-038 Scenario: resiveNChet low for 3 cycles at pair 1 -> pair 1 held for 3 cycles, then pairs 1,2,3 emitted; nothing dropped.
REQ-039 Scenario: three back-to-back frames, input I=0..23 -> pairs (0,1)...(22,23) in order; in_ready=0 only in DRAIN.
REQ-040 Scenario: reset after 5 inputs, then 8 new inputs 50..57 -> output 50,52,54,56 / 51,53,55,57; no stale data.
REQ-041 Scenario: reset during DRAIN at pair 2 -> valid_*=0 next cycle and in_ready=1.
